// File: rtl/ovl_fire_logger.sv
// Fire-event logger for a wrapped OVL checker: timestamps each fire pulse, queues the
// timestamps in a show-ahead FIFO for a valid/ready reader, and keeps sticky flags plus a saturating count.
module ovl_fire_logger #(
  parameter int TS_WIDTH  = 16,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fire,
  input  logic                 clear,
  input  logic                 evt_ready,
  output logic                 evt_valid,
  output logic [TS_WIDTH-1:0]  evt_ts,
  output logic                 evt_lost,
  output logic                 any_fire,
  output logic [CNT_WIDTH-1:0] fire_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [TS_WIDTH-1:0] ts;
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [TS_WIDTH-1:0] mem [DEPTH];

  logic empty;
  logic full;
  logic pop;
  logic push;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot this cycle's push lands in, so full+fire+pop never drops.
  assign pop  = !clear && !empty && evt_ready;
  assign push = !clear && fire && (!full || pop);

  assign evt_valid = !empty;
  assign evt_ts    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fire_count <= '0;
      evt_lost   <= 1'b0;
      any_fire   <= 1'b0;
    end else if (clear) begin
      ts         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fire_count <= '0;
      evt_lost   <= 1'b0;
      any_fire   <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (fire) begin
        any_fire <= 1'b1;
        if (fire_count != CNT_MAX) fire_count <= fire_count + 1'b1;
        if (full && !pop) evt_lost <= 1'b1;
      end
    end
  end

  // NOTE: storage is not reset; stale entries are unreachable because evt_ts is masked when empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= ts;
  end

endmodule

// File: tb/tb_ovl_fire_logger.sv
// Bench for ovl_fire_logger: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a queue-based model of the logger.
module tb_ovl_fire_logger;

  localparam int TSW  = 4;
  localparam int D    = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk;
  logic           rst;
  logic           fire;
  logic           clear;
  logic           evt_ready;
  logic           evt_valid;
  logic [TSW-1:0] evt_ts;
  logic           evt_lost;
  logic           any_fire;
  logic [CW-1:0]  fire_count;

  ovl_fire_logger #(.TS_WIDTH(TSW), .DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .fire      (fire),
    .clear     (clear),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_ts    (evt_ts),
    .evt_lost  (evt_lost),
    .any_fire  (any_fire),
    .fire_count(fire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;

  // Reference model: queue of timestamps plus plain integers.
  int q[$];
  int m_ts;
  int m_cnt;
  bit m_lost;
  bit m_any;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ts   = 0;
    m_cnt  = 0;
    m_lost = 1'b0;
    m_any  = 1'b0;
  endtask

  task automatic model_step(input bit f, input bit r, input bit c);
    bit do_pop;
    bit do_push;
    if (c) begin
      model_reset();
    end else begin
      do_pop  = (q.size() > 0) && r;
      do_push = f && ((q.size() < D) || do_pop);
      if (f) begin
        m_any = 1'b1;
        if (m_cnt < CMAX) m_cnt++;
        if (!do_push) m_lost = 1'b1;
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(m_ts);
      m_ts = (m_ts + 1) % (1 << TSW);
    end
  endtask

  // Drive one cycle's inputs, advance the model at the edge, return just after the next falling edge.
  task automatic cyc(input bit f, input bit r, input bit c);
    fire      = f;
    evt_ready = r;
    clear     = c;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(f, r, c);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (run) begin
      check("cmp_valid", evt_valid, q.size() > 0);
      check("cmp_ts",    evt_ts,    (q.size() > 0) ? q[0] : 0);
      check("cmp_lost",  evt_lost,  m_lost);
      check("cmp_any",   any_fire,  m_any);
      check("cmp_count", fire_count, m_cnt);
    end
  end

  initial begin
    rst       = 1'b1;
    fire      = 1'b0;
    clear     = 1'b0;
    evt_ready = 1'b0;
    model_reset();
    #1;
    check("rst_valid", evt_valid, 0);
    check("rst_ts",    evt_ts,    0);
    check("rst_count", fire_count, 0);
    check("rst_any",   any_fire,  0);
    check("rst_lost",  evt_lost,  0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    run = 1'b1;

    // Single fire after three idle cycles carries timestamp 3, visible one cycle later.
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 0);
    check("t1_valid", evt_valid, 1);
    check("t1_ts",    evt_ts,    3);
    check("t1_count", fire_count, 1);
    check("t1_any",   any_fire,  1);

    // Clear, then six consecutive fires from ts=10 overflow a four-entry FIFO.
    cyc(0, 0, 1);
    check("clr_valid", evt_valid, 0);
    check("clr_count", fire_count, 0);
    repeat (10) cyc(0, 0, 0);
    repeat (6) cyc(1, 0, 0);
    check("t2_lost",  evt_lost,  1);
    check("t2_count", fire_count, 6);
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_valid", evt_valid, 1);
      check("t2_drain_ts",    evt_ts,    10 + i);
      cyc(0, 1, 0);
    end
    check("t2_empty_valid", evt_valid, 0);
    check("t2_empty_ts",    evt_ts,    0);

    // Full FIFO with simultaneous fire and pop: no loss, occupancy stays four.
    cyc(0, 0, 1);
    repeat (4) cyc(1, 0, 0);
    cyc(1, 1, 0);
    check("t3_lost", evt_lost, 0);
    check("t3_head", evt_ts,   1);
    for (int i = 0; i < 4; i++) begin
      check("t3_drain_ts", evt_ts, 1 + i);
      cyc(0, 1, 0);
    end
    check("t3_empty", evt_valid, 0);

    // Timestamp wraps 15 -> 0 with order preserved (ts is 9 here).
    repeat (6) cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("t4_first", evt_ts, 15);
    cyc(0, 1, 0);
    check("t4_second", evt_ts, 0);

    // Clear with a fire and two entries queued wipes everything; the fire is not counted.
    cyc(1, 0, 0);
    cyc(1, 0, 1);
    check("t5_valid", evt_valid, 0);
    check("t5_count", fire_count, 0);
    check("t5_any",   any_fire,  0);
    check("t5_lost",  evt_lost,  0);
    cyc(1, 0, 0);
    check("t5_ts_restart", evt_ts, 0);

    // Ten fires with continuous drain saturate the 3-bit count, then async reset mid-stream.
    repeat (10) cyc(1, 1, 0);
    check("t6_sat", fire_count, 7);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_async_valid", evt_valid, 0);
    check("t6_async_count", fire_count, 0);
    check("t6_async_ts",    evt_ts,    0);
    check("t6_async_any",   any_fire,  0);
    cyc(1, 1, 0);
    rst = 1'b0;

    // Randomized traffic with occasional clears and asynchronous reset pulses.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < ((i < 1500) ? 35 : 70),
          $urandom_range(0, 29) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("rnd_async_valid", evt_valid, 0);
        check("rnd_async_count", fire_count, 0);
        rst = 1'b0;
      end
    end

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
